// File: rtl/alu_sequencer.sv
// Command sequencer for an external combinational ALU: queues commands in a
// small FIFO, issues one at a time, and holds each result until it is consumed.
module alu_sequencer #(
  parameter int N     = 16,
  parameter int M     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         Cmd_Valid,
  output logic         Cmd_Ready,
  input  logic [M-1:0] Cmd_Mode,
  input  logic [N-1:0] Cmd_A,
  input  logic [N-1:0] Cmd_B,
  input  logic         Cmd_Cin,
  input  logic         Cmd_Chain,
  output logic [N-1:0] Alu_A,
  output logic [N-1:0] Alu_B,
  output logic         Alu_Cin,
  output logic [M-1:0] Alu_Mode,
  input  logic [N-1:0] Alu_Y,
  input  logic         Alu_Cout,
  input  logic         Alu_Overflow,
  output logic         Res_Valid,
  input  logic         Res_Ready,
  output logic [N-1:0] Res_Y,
  output logic         Res_Cout,
  output logic         Res_Overflow,
  output logic         Sticky_Ovf,
  input  logic         Clr_Sticky,
  output logic         Busy
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [M-1:0] mode;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         chain;
  } cmd_t;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  logic [N-1:0]  last_y;
  state_t        state_q, state_d;

  // Extra MSB on the pointers distinguishes full from empty.
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign Cmd_Ready = !full;
  assign push      = Cmd_Valid && !full;
  assign pop       = (state_q == ST_IDLE) && !empty;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign Busy      = (state_q != ST_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{mode: Cmd_Mode, a: Cmd_A, b: Cmd_B,
                                       cin: Cmd_Cin, chain: Cmd_Chain};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!empty) state_d = ST_WAIT;
      ST_WAIT: state_d = ST_HOLD;
      ST_HOLD: if (Res_Ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Alu_A        <= '0;
      Alu_B        <= '0;
      Alu_Cin      <= 1'b0;
      Alu_Mode     <= '0;
      Res_Valid    <= 1'b0;
      Res_Y        <= '0;
      Res_Cout     <= 1'b0;
      Res_Overflow <= 1'b0;
      last_y       <= '0;
      Sticky_Ovf   <= 1'b0;
    end else begin
      if (pop) begin
        Alu_A    <= head.chain ? last_y : head.a;
        Alu_B    <= head.b;
        Alu_Cin  <= head.cin;
        Alu_Mode <= head.mode;
      end
      if (state_q == ST_WAIT) begin
        Res_Y        <= Alu_Y;
        Res_Cout     <= Alu_Cout;
        Res_Overflow <= Alu_Overflow;
        last_y       <= Alu_Y;
        Res_Valid    <= 1'b1;
      end else if (state_q == ST_HOLD && Res_Ready) begin
        Res_Valid <= 1'b0;
      end
      // A capture wins over a simultaneous clear.
      if (state_q == ST_WAIT && Alu_Overflow) Sticky_Ovf <= 1'b1;
      else if (Clr_Sticky)                     Sticky_Ovf <= 1'b0;
    end
  end
endmodule
